// File: rtl/alu_seq_if.sv
// Request/result bundle between the register-file read stage and alu_seq.
// With ALU_SEQ_FLAGS_EN defined the bundle also carries the {N,Z,C,V} flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       S;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] R;
    logic             dbgState;   // 1 while the sequencer is iterating a MOD
`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]       flags;

    modport master (output start, A, B, S, input busy, done, dz, R, flags, dbgState);
    modport slave  (input start, A, B, S, output busy, done, dz, R, flags, dbgState);
`else
    modport master (output start, A, B, S, input busy, done, dz, R, dbgState);
    modport slave  (input start, A, B, S, output busy, done, dz, R, dbgState);
`endif
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/busy/done handshake and multi-cycle unsigned MOD.
// Optional {N,Z,C,V} status flags are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    // Handshake: a start is accepted only in IDLE; done is a one-cycle pulse
    // that qualifies R/dz (and flags), which then hold until the next done.
    typedef enum logic {IDLE = 1'b0, DIV = 1'b1} stateT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [WIDTH-1:0] aSh, aShNext, bReg, bRegNext, rem, remNext, rReg, rNext;
    logic             busyReg, busyNext, doneReg, doneNext, dzReg, dzNext;
    logic [WIDTH-1:0] opResult, addSum, subDiff, remStep;
    logic [WIDTH:0]   remWide;
    logic             isMod;

`ifdef ALU_SEQ_FLAGS_EN
    logic       addCarry, subCarry, addOvf, subOvf, opCarry, opOvf;
    logic [3:0] flagsReg, flagsNext, opFlags;

    assign {addCarry, addSum}  = {1'b0, bus.A} + {1'b0, bus.B};
    assign {subCarry, subDiff} = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
    assign addOvf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (addSum[WIDTH-1] != bus.A[WIDTH-1]);
    assign subOvf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (subDiff[WIDTH-1] != bus.A[WIDTH-1]);
    assign opCarry = (bus.S == 3'b101) ? addCarry : (bus.S == 3'b110) ? subCarry : 1'b0;
    assign opOvf   = (bus.S == 3'b101) ? addOvf   : (bus.S == 3'b110) ? subOvf   : 1'b0;
    assign opFlags = {opResult[WIDTH-1], opResult == '0, opCarry, opOvf};
    assign bus.flags = flagsReg;
`else
    assign addSum  = bus.A + bus.B;
    assign subDiff = bus.A + ~bus.B + WIDTH'(1);
`endif

    assign isMod = (bus.S == 3'b111);

    always_comb begin
        opResult = '0;
        case (bus.S)
            3'b000:  opResult = bus.A & bus.B;
            3'b001:  opResult = bus.A | bus.B;
            3'b010:  opResult = bus.A ^ bus.B;
            3'b011:  opResult = ~(bus.A | bus.B);
            3'b100:  opResult = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            3'b101:  opResult = addSum;
            3'b110:  opResult = subDiff;
            default: opResult = bus.A;   // divide-by-zero returns the dividend
        endcase
    end

    // Partial remainder is always < B, so after the shift it fits in WIDTH+1 bits
    // and the subtracted value fits back in WIDTH bits.
    assign remWide = {rem, aSh[WIDTH-1]};
    assign remStep = (remWide >= {1'b0, bReg}) ? (remWide[WIDTH-1:0] - bReg) : remWide[WIDTH-1:0];

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        aShNext   = aSh;
        bRegNext  = bReg;
        remNext   = rem;
        rNext     = rReg;
        busyNext  = busyReg;
        doneNext  = 1'b0;
        dzNext    = dzReg;
`ifdef ALU_SEQ_FLAGS_EN
        flagsNext = flagsReg;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (isMod && (bus.B != '0)) begin
                        aShNext   = bus.A;
                        bRegNext  = bus.B;
                        remNext   = '0;
                        cntNext   = CNT_W'(WIDTH);
                        busyNext  = 1'b1;
                        stateNext = DIV;
                    end else begin
                        rNext    = opResult;
                        doneNext = 1'b1;
                        dzNext   = isMod;
`ifdef ALU_SEQ_FLAGS_EN
                        flagsNext = opFlags;
`endif
                    end
                end
            end
            DIV: begin
                aShNext = aSh << 1;
                remNext = remStep;
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rNext     = remStep;
                    doneNext  = 1'b1;
                    dzNext    = 1'b0;
                    busyNext  = 1'b0;
                    stateNext = IDLE;
`ifdef ALU_SEQ_FLAGS_EN
                    flagsNext = {remStep[WIDTH-1], remStep == '0, 2'b00};
`endif
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            aSh     <= '0;
            bReg    <= '0;
            rem     <= '0;
            rReg    <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            dzReg   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            flagsReg <= '0;
`endif
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            aSh     <= aShNext;
            bReg    <= bRegNext;
            rem     <= remNext;
            rReg    <= rNext;
            busyReg <= busyNext;
            doneReg <= doneNext;
            dzReg   <= dzNext;
`ifdef ALU_SEQ_FLAGS_EN
            flagsReg <= flagsNext;
`endif
        end
    end

    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.dz       = dzReg;
    assign bus.R        = rReg;
    assign bus.dbgState = (state == DIV);
endmodule
